regfile_dump_ctrl: RTL

- Debug-port reader for the 32-entry register file: on request, walks `dbg_addr` from x0 to x31 and samples `dbg_data`.
- Emits each register as one word on a valid/ready stream, tagged with its address and a last flag.
- Sits between the register file debug port and a host-side sink (UART bridge, trace buffer).
- Dump is non-intrusive; it never touches `we3`/`wa3`/`wd3`.

---
 rtl/regdump_pkg.sv | 24 ++
 rtl/regfile_dump_ctrl_if.sv | 32 +++
 rtl/regfile_dump_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump controller.
// Holds the FSM state encoding and the default entry count.
// REGDUMP_CHECKSUM_EN adds the CKSUM state used for the trailing XOR word.
package regdump_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int N_REGS         = 2**DEF_ADDR_WIDTH;

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_CKSUM = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Dump output stream: one register word per valid/ready handshake.
// No latency of its own; pure signal bundle.
// Source holds m_valid/m_data/m_addr/m_last stable until m_ready is seen.
interface regfile_dump_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    import regdump_pkg::*;

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_addr,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_addr,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Walks the register-file debug port x0..x(N-1) and streams each word with address/last tags.
// Latency: 2 cycles per word unstalled; done pulses 2*N cycles after start is accepted.
// Backpressure: word held in SEND until m_ready; optional REGDUMP_CHECKSUM_EN appends an XOR word.
module regfile_dump_ctrl
    import regdump_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    regfile_dump_ctrl_if.master   m
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_dbg_addr;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic                  r_m_last;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_acc;
`endif

    logic w_at_last;

    // The debug address counter only ever advances off a non-final handshake,
    // so it stops at LAST_ADDR and cannot wrap.
    assign w_at_last = (r_dbg_addr == LAST_ADDR);

    // Dump sequencer: address walk, word capture, stream hold and completion pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbg_addr <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_addr   <= '0;
            r_m_last   <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            r_acc      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dbg_addr <= '0;
                        r_busy     <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                        r_acc      <= '0;
`endif
                        r_state    <= ST_FETCH;
                    end
                end

                // dbg_addr was registered last cycle, so dbg_data has settled.
                ST_FETCH: begin
                    r_m_data  <= dbg_data;
                    r_m_addr  <= r_dbg_addr;
                    r_m_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    r_m_last  <= 1'b0;
                    r_acc     <= r_acc ^ dbg_data;
`else
                    r_m_last  <= w_at_last;
`endif
                    r_state   <= ST_SEND;
                end

                ST_SEND: begin
                    if (m.m_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                        if (r_m_addr == LAST_ADDR) begin
                            // Accumulator already holds the last word; keep valid high
                            // and present the checksum directly, no debug read needed.
                            r_m_data <= r_acc;
                            r_m_addr <= '0;
                            r_m_last <= 1'b1;
                            r_state  <= ST_CKSUM;
                        end else begin
                            r_m_valid  <= 1'b0;
                            r_dbg_addr <= r_dbg_addr + ADDR_ONE;
                            r_state    <= ST_FETCH;
                        end
`else
                        if (r_m_last) begin
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_m_valid  <= 1'b0;
                            r_dbg_addr <= r_dbg_addr + ADDR_ONE;
                            r_state    <= ST_FETCH;
                        end
`endif
                    end
                end

`ifdef REGDUMP_CHECKSUM_EN
                ST_CKSUM: begin
                    if (m.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_addr  = r_dbg_addr;
    assign m.m_valid = r_m_valid;
    assign m.m_data  = r_m_data;
    assign m.m_addr  = r_m_addr;
    assign m.m_last  = r_m_last;

endmodule
